bp_be_fe_cmd_arbiter: RTL and testbench
=======================================

// Module: bp_be_fe_cmd_arbiter
// PURPOSE
//  Shares the backend->frontend command channel between up to num_req_p internal requesters
//  (redirect/branch, PTW fill, fence/itlb/icache maintenance) and buffers granted commands
//  in an els_p-deep FIFO. The FIFO drains to the FE through a valid/yumi handshake.
//  Sits between the director-side command sources and fe_cmd_o/fe_cmd_v_o/fe_cmd_yumi_i.
//  Exports occupancy so the detector can stall issue before the channel backs up.
// PARAMETERS
//  cmd_width_p   64  width of one FE command (packed bp_fe_cmd_s)
//  num_req_p     3   number of requesters; index 0 has highest priority
//  els_p         4   FIFO depth; power of 2, >= 2
// PORTS
//  clk_i          in   1                      clock
//  reset_i        in   1                      synchronous, active-high reset
//  req_v_i        in   num_req_p              per-requester command valid
//  req_cmd_i      in   num_req_p*cmd_width_p  per-requester command; slice i = [i*cmd_width_p+:cmd_width_p]
//  req_grant_o    out  num_req_p              one-hot grant; command enqueued this cycle
//  flush_i        in   1                      discard all buffered commands
//  fe_cmd_o       out  cmd_width_p            FIFO head command
//  fe_cmd_v_o     out  1                      FIFO head valid
//  fe_cmd_yumi_i  in   1                      FE consumes head this cycle
//  full_o         out  1                      count == els_p
//  empty_o        out  1                      count == 0
//  count_o        out  $clog2(els_p+1)        buffered command count
// BEHAVIOUR
//  - Reset: count=0, rd/wr pointers=0; fe_cmd_v_o=0, full_o=0, empty_o=1, req_grant_o=0.
//    Storage is not reset; fe_cmd_o is don't-care while fe_cmd_v_o=0.
//  - Arbitration is fixed priority. grant[i] = req_v_i[i] & ~|req_v_i[i-1:0] & ~full_o & ~flush_i.
//  - At most one enqueue per cycle. Losing requesters hold req_v_i/req_cmd_i stable until granted.
//  - req_grant_o is combinational from req_v_i and registered state.
//  - full_o comes from the registered count only. A same-cycle yumi does NOT free a slot for
//    enqueue (no full bypass).
//  - No enqueue->dequeue bypass: a command granted in cycle N is visible on fe_cmd_o and
//    fe_cmd_v_o in cycle N+1 at the earliest. Latency is 1 cycle when the FIFO is empty.
//  - fe_cmd_v_o = ~empty_o. fe_cmd_o = mem[rd_ptr], driven from registered state.
//  - Handshake: fe_cmd_yumi_i is legal only while fe_cmd_v_o=1; yumi while empty is an error
//    (assertion). fe_cmd_o and fe_cmd_v_o hold stable until yumi.
//  - Simultaneous enqueue and dequeue (count in 1..els_p-1): count is unchanged and both
//    pointers advance.
//  - Pointers are log2(els_p) bits wide and wrap naturally from els_p-1 to 0.
//    count_o ranges 0..els_p inclusive.
//  - flush_i: in the same cycle, grants are forced to 0 and any yumi is ignored. Next cycle:
//    count=0, rd_ptr=wr_ptr=0, fe_cmd_v_o=0. Flush takes priority over every other event.
//  - Reset asserted mid-operation: behaves exactly like flush plus the reset values above.
//  - FIFO order is preserved: commands leave in grant order, independent of requester index.
//  - Assertions: grant is one-hot0; count never exceeds els_p; no yumi while empty.
// TESTING
//  1 Reset, then req_v_i=3'b001 with cmd=0xA for 1 cycle -> grant=001 in that cycle;
//    next cycle fe_cmd_v_o=1, fe_cmd_o=0xA, count_o=1.
//  2 req_v_i=3'b110 held with cmds B (req1) and C (req2) -> grant=010 first, then grant=100
//    next cycle; FE drains in order B then C.
//  3 yumi held low, 4 grants (0x1..0x4) -> full_o=1, count_o=4, grant=000 while req_v_i=001
//    persists; single yumi -> 0x1 popped, grant of 0x5 allowed only in the following cycle.
//  4 count=2 with enqueue 0x7 and yumi in the same cycle -> count stays 2; pointers wrap
//    past index 3 across 6 such cycles; output order is correct.
//  5 count=3 with flush_i=1, yumi=1 and req_v_i=001 together -> grant=000; next cycle count=0,
//    fe_cmd_v_o=0; the following grant lands at index 0.
//  6 reset_i pulsed while count=2 -> next cycle empty_o=1; yumi while empty triggers the
//    assertion (negative test).

Source files
------------

// File: rtl/bp_be_fe_cmd_arbiter.sv
// Fixed-priority arbiter feeding a small FIFO that buffers backend->frontend commands.
// The FIFO drains to the FE via a valid/yumi handshake.
module bp_be_fe_cmd_arbiter #(
  parameter int unsigned cmd_width_p = 64,
  parameter int unsigned num_req_p   = 3,
  parameter int unsigned els_p       = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p*cmd_width_p-1:0]   req_cmd_i,
  output logic [num_req_p-1:0]               req_grant_o,
  input  logic                               flush_i,
  output logic [cmd_width_p-1:0]             fe_cmd_o,
  output logic                               fe_cmd_v_o,
  input  logic                               fe_cmd_yumi_i,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(els_p+1)-1:0]         count_o
);

  localparam int unsigned cnt_w = $clog2(els_p + 1);
  localparam int unsigned ptr_w = $clog2(els_p);

  logic [cmd_width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]       rd_ptr;
  logic [ptr_w-1:0]       wr_ptr;
  logic [cnt_w-1:0]       count_r;
  logic [cmd_width_p-1:0] wr_cmd;
  logic                   blocked;
  logic                   enq;
  logic                   deq;

  // Lowest index wins; a full FIFO, flush or reset blocks every grant.
  always_comb begin
    req_grant_o = '0;
    wr_cmd      = '0;
    blocked     = full_o | flush_i | reset_i;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (req_v_i[i] && !blocked) begin
        req_grant_o[i] = 1'b1;
        wr_cmd         = req_cmd_i[i*cmd_width_p +: cmd_width_p];
        blocked        = 1'b1;
      end
    end
  end

  assign enq = |req_grant_o;
  assign deq = fe_cmd_yumi_i & ~empty_o & ~flush_i;

  assign full_o     = (count_r == cnt_w'(els_p));
  assign empty_o    = (count_r == '0);
  assign fe_cmd_v_o = ~empty_o;
  assign fe_cmd_o   = mem[rd_ptr];
  assign count_o    = count_r;

  // Flush and reset share the same clearing path.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + ptr_w'(1);
      if (deq) rd_ptr <= rd_ptr + ptr_w'(1);
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage carries no reset; validity comes from count_r.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= wr_cmd;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(req_grant_o));
      assert (count_r <= cnt_w'(els_p));
      assert (!(fe_cmd_yumi_i && empty_o));
    end
  end

endmodule

// File: tb/tb_bp_be_fe_cmd_arbiter.sv
// Directed bench for bp_be_fe_cmd_arbiter: expected commands are queued at grant time
// and checked by an independent monitor when the FE consumes them.
module tb_bp_be_fe_cmd_arbiter;

  localparam int unsigned cw = 64;
  localparam int unsigned nr = 3;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [nr-1:0]   req_v_i;
  logic [nr*cw-1:0] req_cmd_i;
  logic [nr-1:0]   req_grant_o;
  logic            flush_i;
  logic [cw-1:0]   fe_cmd_o;
  logic            fe_cmd_v_o;
  logic            fe_cmd_yumi_i;
  logic            full_o;
  logic            empty_o;
  logic [2:0]      count_o;

  int checks   = 0;
  int failures = 0;
  logic [cw-1:0] sb[$];

  bp_be_fe_cmd_arbiter #(.cmd_width_p(cw), .num_req_p(nr), .els_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_cmd_i(req_cmd_i),
    .req_grant_o(req_grant_o), .flush_i(flush_i), .fe_cmd_o(fe_cmd_o),
    .fe_cmd_v_o(fe_cmd_v_o), .fe_cmd_yumi_i(fe_cmd_yumi_i), .full_o(full_o),
    .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [cw-1:0] act, input logic [cw-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [nr-1:0] v, input logic y, input logic f);
    req_v_i       = v;
    fe_cmd_yumi_i = y;
    flush_i       = f;
    #1;
  endtask

  task automatic set_cmd(input int idx, input logic [cw-1:0] c);
    req_cmd_i[idx*cw +: cw] = c;
  endtask

  // Monitor: every accepted head must match the oldest outstanding expected command.
  always @(negedge clk) begin
    if (!reset_i && !flush_i && fe_cmd_yumi_i) begin
      if (!fe_cmd_v_o) begin
        checks++; failures++;
        $display("FAIL yumi_valid: got v=0 expected v=1 at %0t", $time);
      end else if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: got cmd 0x%0h expected none at %0t", fe_cmd_o, $time);
      end else begin
        chk("fe_cmd", fe_cmd_o, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    req_cmd_i = '0;
    set(3'b000, 1'b0, 1'b0);
    tick(); tick();
    // Grants stay low while reset is held.
    set(3'b001, 1'b0, 1'b0);
    chk("rst_grant", 64'(req_grant_o), 64'h0);
    chk("rst_empty", 64'(empty_o), 64'h1);
    chk("rst_v", 64'(fe_cmd_v_o), 64'h0);
    chk("rst_full", 64'(full_o), 64'h0);
    chk("rst_count", 64'(count_o), 64'h0);
    tick();
    reset_i = 1'b0;

    // Single grant, one-cycle latency.
    set_cmd(0, 64'hA);
    set(3'b001, 1'b0, 1'b0);
    chk("t1_grant", 64'(req_grant_o), 64'h1);
    sb.push_back(64'hA);
    tick();
    set(3'b000, 1'b0, 1'b0);
    chk("t1_v", 64'(fe_cmd_v_o), 64'h1);
    chk("t1_cmd", fe_cmd_o, 64'hA);
    chk("t1_count", 64'(count_o), 64'h1);
    set(3'b000, 1'b1, 1'b0);
    tick();
    set(3'b000, 1'b0, 1'b0);
    chk("t1_empty", 64'(empty_o), 64'h1);

    // Priority between requesters 1 and 2.
    set_cmd(1, 64'hB);
    set_cmd(2, 64'hC);
    set(3'b110, 1'b0, 1'b0);
    chk("t2_grant1", 64'(req_grant_o), 64'h2);
    sb.push_back(64'hB);
    tick();
    set(3'b100, 1'b0, 1'b0);
    chk("t2_grant2", 64'(req_grant_o), 64'h4);
    sb.push_back(64'hC);
    tick();
    set(3'b000, 1'b1, 1'b0);
    tick();
    set(3'b000, 1'b1, 1'b0);
    tick();
    set(3'b000, 1'b0, 1'b0);
    chk("t2_empty", 64'(empty_o), 64'h1);

    // Fill to full; yumi does not free a slot in the same cycle.
    for (int k = 1; k <= 4; k++) begin
      set_cmd(0, 64'(k));
      set(3'b001, 1'b0, 1'b0);
      chk("t3_fill_grant", 64'(req_grant_o), 64'h1);
      sb.push_back(64'(k));
      tick();
    end
    set_cmd(0, 64'h5);
    set(3'b001, 1'b0, 1'b0);
    chk("t3_full", 64'(full_o), 64'h1);
    chk("t3_count4", 64'(count_o), 64'h4);
    chk("t3_grant_full", 64'(req_grant_o), 64'h0);
    tick();
    set(3'b001, 1'b1, 1'b0);
    chk("t3_grant_nobypass", 64'(req_grant_o), 64'h0);
    tick();
    set(3'b001, 1'b0, 1'b0);
    chk("t3_count3", 64'(count_o), 64'h3);
    chk("t3_grant_after", 64'(req_grant_o), 64'h1);
    sb.push_back(64'h5);
    tick();
    set(3'b000, 1'b0, 1'b0);
    chk("t3_count_refill", 64'(count_o), 64'h4);
    for (int k = 0; k < 4; k++) begin
      set(3'b000, 1'b1, 1'b0);
      tick();
    end
    set(3'b000, 1'b0, 1'b0);
    chk("t3_empty", 64'(empty_o), 64'h1);

    // Simultaneous enqueue/dequeue at count=2, wrapping the pointers.
    for (int k = 0; k < 2; k++) begin
      set_cmd(0, 64'(8'h10 + k));
      set(3'b001, 1'b0, 1'b0);
      sb.push_back(64'(8'h10 + k));
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      set_cmd(0, 64'(8'h70 + k));
      set(3'b001, 1'b1, 1'b0);
      chk("t4_grant", 64'(req_grant_o), 64'h1);
      chk("t4_count", 64'(count_o), 64'h2);
      sb.push_back(64'(8'h70 + k));
      tick();
    end
    set(3'b000, 1'b0, 1'b0);
    chk("t4_count_end", 64'(count_o), 64'h2);

    // Flush at count=3 with yumi and a request in the same cycle.
    set_cmd(0, 64'h80);
    set(3'b001, 1'b0, 1'b0);
    sb.push_back(64'h80);
    tick();
    set(3'b001, 1'b1, 1'b1);
    chk("t5_count3", 64'(count_o), 64'h3);
    chk("t5_grant_flush", 64'(req_grant_o), 64'h0);
    sb.delete();
    tick();
    set(3'b000, 1'b0, 1'b0);
    chk("t5_count0", 64'(count_o), 64'h0);
    chk("t5_v", 64'(fe_cmd_v_o), 64'h0);
    set_cmd(0, 64'h99);
    set(3'b001, 1'b0, 1'b0);
    chk("t5_regrant", 64'(req_grant_o), 64'h1);
    sb.push_back(64'h99);
    tick();
    set(3'b000, 1'b0, 1'b0);
    chk("t5_cmd", fe_cmd_o, 64'h99);
    chk("t5_count1", 64'(count_o), 64'h1);

    // Reset mid-operation at count=2.
    set_cmd(0, 64'h9A);
    set(3'b001, 1'b0, 1'b0);
    sb.push_back(64'h9A);
    tick();
    reset_i = 1'b1;
    set(3'b000, 1'b0, 1'b0);
    chk("t6_count2", 64'(count_o), 64'h2);
    sb.delete();
    tick();
    reset_i = 1'b0;
    set(3'b000, 1'b0, 1'b0);
    chk("t6_empty", 64'(empty_o), 64'h1);
    chk("t6_count0", 64'(count_o), 64'h0);

    // All requesters at once: index 0 wins.
    set_cmd(0, 64'h5A);
    set(3'b111, 1'b0, 1'b0);
    chk("t6_grant_all", 64'(req_grant_o), 64'h1);
    sb.push_back(64'h5A);
    tick();
    set(3'b000, 1'b1, 1'b0);
    tick();
    set(3'b000, 1'b0, 1'b0);
    chk("end_empty", 64'(empty_o), 64'h1);
    chk("end_sb", 64'(sb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
